// File: rtl/tri_fu_mul_bthseq.sv
// Iterative signed radix-4 Booth multiplier: one partial product per cycle,
// valid/ready on both sides, synchronous kill.
module tri_fu_mul_bthseq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               kill,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  // state  | meaning
  // IDLE   | waiting for an operand pair, in_ready high
  // RUN    | one Booth window per cycle, accumulating partial products
  // DONE   | product presented on out_p until out_ready

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH / 2);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   a_sh, acc, mag, pp, acc_sum, p_q;
  logic [WIDTH-1:0] b_sh;
  logic            b_prev;
  logic [CW-1:0]   cnt;
  logic            neg, x, x2, accept, last;

  assign accept    = (state == S_IDLE) & in_valid & ~kill;
  assign last      = (cnt == '0);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_p     = p_q;

  // a_sh carries the multiplicand pre-shifted by 2*window index, so the
  // window counter only has to mark the last step.
  always_comb begin
    neg = b_sh[1];
    x   = b_sh[0] ^ b_prev;
    x2  = (b_sh[1] & ~b_sh[0] & ~b_prev) | (~b_sh[1] & b_sh[0] & b_prev);
    mag = '0;
    if (x)
      mag = a_sh;
    else if (x2)
      mag = {a_sh[PW-2:0], 1'b0};
    pp      = neg ? (~mag + PW'(1)) : mag;
    acc_sum = acc + pp;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_RUN;
      S_RUN:  if (last) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (kill)
      state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_sh   <= '0;
      b_sh   <= '0;
      b_prev <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      p_q    <= '0;
    end else if (kill) begin
      acc <= '0;
      cnt <= '0;
      p_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh   <= {{WIDTH{in_a[WIDTH-1]}}, in_a};
            b_sh   <= in_b;
            b_prev <= 1'b0;
            acc    <= '0;
            cnt    <= CNT_LOAD;
          end
        end
        S_RUN: begin
          acc    <= acc_sum;
          a_sh   <= {a_sh[PW-3:0], 2'b00};
          b_prev <= b_sh[1];
          b_sh   <= {{2{b_sh[WIDTH-1]}}, b_sh[WIDTH-1:2]};
          cnt    <= cnt - CW'(1);
          if (last)
            p_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_fu_mul_bthseq.sv
// Directed-vector and corner-sequence bench for tri_fu_mul_bthseq (WIDTH=16).
module tb_tri_fu_mul_bthseq;

  logic        clk;
  logic        rst_b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic        busy;

  int n_pass = 0;
  int n_tot  = 0;

  tri_fu_mul_bthseq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [31:0] p;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready)
      chk({nm, "_rdy_timeout"}, 32'(in_ready), 32'd1);
  endtask

  task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input string nm);
    wait_ready(nm);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string nm);
    int lat;
    out_ready = 1'b1;
    accept_op(a, b, nm);
    wait_valid(lat);
    chk({nm, "_lat"}, 32'(lat), 32'd8);
    chk({nm, "_p"}, out_p, exp);
    tick();
    chk({nm, "_ovdrop"}, 32'(out_valid), 32'd0);
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic no_valid_for(input int cycles, input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      seen = seen | out_valid;
      tick();
    end
    chk({nm, "_no_ov"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic signed [15:0] ra, rb;
    logic signed [31:0] re;
    int killat, k;
    logic done;

    vecs[0]  = '{a:  16'sd3,      b:  16'sd5,      p: 32'sd15};
    vecs[1]  = '{a: -16'sd32768,  b: -16'sd32768,  p: 32'sh40000000};
    vecs[2]  = '{a:  16'sd32767,  b: -16'sd32768,  p: -32'sd1073709056};
    vecs[3]  = '{a:  16'sd32767,  b:  16'sd32767,  p: 32'sd1073676289};
    vecs[4]  = '{a: -16'sd7,      b:  16'sd9,      p: -32'sd63};
    vecs[5]  = '{a:  16'sd2,      b: -16'sd1,      p: -32'sd2};
    vecs[6]  = '{a:  16'sd0,      b: -16'sd1,      p: 32'sd0};
    vecs[7]  = '{a: -16'sd1,      b: -16'sd1,      p: 32'sd1};
    vecs[8]  = '{a: -16'sd32768,  b:  16'sd1,      p: -32'sd32768};
    vecs[9]  = '{a:  16'sd1,      b: -16'sd32768,  p: -32'sd32768};
    vecs[10] = '{a: -16'sd3,      b: -16'sd5,      p: 32'sd15};
    vecs[11] = '{a:  16'sd12345,  b: -16'sd2,      p: -32'sd24690};

    clk = 1'b0; rst_b = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    kill = 1'b0; out_ready = 1'b1;

    #2;
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_rdy",    32'(in_ready),  32'd1);
    chk("rst_ov",     32'(out_valid), 32'd0);
    chk("rst_p",      out_p,          32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    for (int i = 0; i < NV; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // Backpressure: result must hold, new offers ignored.
    out_ready = 1'b0;
    accept_op(-16'sd7, 16'sd9, "bp");
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_p%0d", i),   out_p,           -32'sd63);
      chk($sformatf("bp_rdy%0d", i), 32'(in_ready),  32'd0);
      chk($sformatf("bp_ov%0d", i),  32'(out_valid), 32'd1);
      in_valid = 1'b1;
      in_a     = 16'h1234;
      in_b     = 16'h0101;
      tick();
      in_valid = 1'b0;
    end
    chk("bp_p_hold", out_p, -32'sd63);
    out_ready = 1'b1;
    tick();
    chk("bp_ovdrop", 32'(out_valid), 32'd0);
    chk("bp_idle",   32'(busy),      32'd0);
    chk("bp_p_keep", out_p,          -32'sd63);
    no_valid_for(10, "bp_after");

    // Kill during RUN after three windows.
    accept_op(16'sd5, 16'sd7, "krun");
    tick(); tick(); tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("krun_busy", 32'(busy),      32'd0);
    chk("krun_ov",   32'(out_valid), 32'd0);
    chk("krun_p",    out_p,          32'd0);
    no_valid_for(12, "krun");
    do_op(16'sd2, -16'sd1, -32'sd2, "post_kill");

    // Kill while holding a result in DONE.
    out_ready = 1'b0;
    accept_op(16'sd100, 16'sd100, "kdone");
    wait_valid(lat);
    chk("kdone_ov_before", 32'(out_valid), 32'd1);
    chk("kdone_p_before",  out_p,          32'd10000);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kdone_ov",  32'(out_valid), 32'd0);
    chk("kdone_p",   out_p,          32'd0);
    chk("kdone_rdy", 32'(in_ready),  32'd1);
    out_ready = 1'b1;

    // Kill together with in_valid in IDLE must not accept.
    kill = 1'b1; in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9;
    tick();
    kill = 1'b0; in_valid = 1'b0;
    chk("kidle_busy", 32'(busy), 32'd0);
    no_valid_for(10, "kidle");

    // Asynchronous reset mid-RUN, not aligned to a clock edge.
    do_op(16'sd2, -16'sd1, -32'sd2, "pre_rst");
    accept_op(16'sd9, 16'sd9, "arst");
    tick(); tick(); tick();
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_busy", 32'(busy),      32'd0);
    chk("arst_rdy",  32'(in_ready),  32'd1);
    chk("arst_ov",   32'(out_valid), 32'd0);
    chk("arst_p",    out_p,          32'd0);
    #3;
    rst_b = 1'b1;
    tick();
    no_valid_for(12, "arst");
    do_op(16'sd0, -16'sd1, 32'sd0, "post_rst");

    // Random operands with random backpressure and occasional kill.
    for (int i = 0; i < 1500; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      re = ra * rb;
      killat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : 0;
      for (int g = int'($urandom_range(0, 2)); g > 0; g--)
        tick();
      accept_op(ra, rb, "rnd");
      k = 0;
      done = 1'b0;
      while (!done && k < 80) begin
        if (killat != 0 && k == killat) begin
          kill = 1'b1;
          out_ready = 1'b0;
          tick();
          kill = 1'b0;
          chk($sformatf("rnd%0d_kill_ov", i), 32'(out_valid), 32'd0);
          done = 1'b1;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            chk($sformatf("rnd%0d_p", i), out_p, re);
            tick();
            chk($sformatf("rnd%0d_ovdrop", i), 32'(out_valid), 32'd0);
            done = 1'b1;
          end else begin
            tick();
            k++;
          end
        end
      end
      chk($sformatf("rnd%0d_done", i), 32'(done), 32'd1);
    end
    out_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
